// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment bus capture block.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sseg_pkg;

    localparam int NUM_DIGITS = 8;

    // All segments off, dp off (active-low bus).
    localparam logic [7:0] SSEG_BLANK = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0-9, A, b, C, d, E, F.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'b1000000, // 0
        7'b1111001, // 1
        7'b0100100, // 2
        7'b0110000, // 3
        7'b0011001, // 4
        7'b0010010, // 5
        7'b0000010, // 6
        7'b1111000, // 7
        7'b0000000, // 8
        7'b0010000, // 9
        7'b0001000, // A
        7'b0000011, // b
        7'b1000110, // C
        7'b0100001, // d
        7'b0000110, // E
        7'b0001110  // F
    };

    // Classification of the registered digit-enable vector.
    typedef enum logic [1:0] {
        STROBE_BLANK,
        STROBE_LEGAL,
        STROBE_ILLEGAL
    } strobe_t;

endpackage

// File: rtl/sseg_hex_decode.sv
// Maps a 7-bit active-low segment image back to a hex nibble.
// Latency: combinational.
// Backpressure: none; pure function of the input pattern.
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       ok,
    output logic [3:0] nibble
);

    // Glyphs are all distinct, so at most one entry can match.
    always_comb begin
        ok     = 1'b0;
        nibble = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (pattern == HEX_GLYPH[k]) begin
                ok     = 1'b1;
                nibble = 4'(k);
            end
        end
    end

endmodule

// File: rtl/sseg_capture.sv
// Passive receiver for the multiplexed seven-segment bus; rebuilds and decodes per-digit images.
// Latency: capture lands STABLE_CYCLES edges after the first edge that samples a new pin value.
// Backpressure: none; it only observes the bus and never stalls the driver.
module sseg_capture
    import sseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic [7:0]  DIGIT_MASK    = 8'h0F
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_DIGITS-1:0]     an_in,
    input  logic [7:0]                sseg_in,
    output logic [8*NUM_DIGITS-1:0]   digit_pat,
    output logic [4*NUM_DIGITS-1:0]   hex_val,
    output logic [NUM_DIGITS-1:0]     hex_ok,
    output logic [NUM_DIGITS-1:0]     dp_val,
    output logic                      frame_tick,
    output logic [7:0]                err_cnt
);

    localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_QUAL = 8'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0] an_r;
    logic [7:0]            sseg_r;
    logic [7:0]            cnt;
    logic                  pins_eq;
    logic                  qualify;
    logic [3:0]            low_cnt;
    logic [2:0]            sel;
    strobe_t               strobe;
    logic                  dec_ok;
    logic [3:0]            dec_nib;
    logic [NUM_DIGITS-1:0] seen;
    logic [NUM_DIGITS-1:0] seen_next;
    logic                  frame_done;

    assign pins_eq = ({an_in, sseg_in} == {an_r, sseg_r});
    // The count saturates at CNT_MAX, so CNT_QUAL is passed exactly once per dwell.
    assign qualify = pins_eq && (cnt == CNT_QUAL);

    // Classify the registered strobe and find the selected digit.
    always_comb begin
        low_cnt = 4'd0;
        sel     = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_r[i]) begin
                low_cnt = low_cnt + 4'd1;
                sel     = 3'(i);
            end
        end
        if (low_cnt == 4'd0) begin
            strobe = STROBE_BLANK;
        end else if (low_cnt == 4'd1) begin
            strobe = STROBE_LEGAL;
        end else begin
            strobe = STROBE_ILLEGAL;
        end
    end

    // Frame completes when the capture being made fills the last masked digit.
    always_comb begin
        seen_next  = seen | (NUM_DIGITS'(1) << sel);
        frame_done = ((seen_next & DIGIT_MASK) == DIGIT_MASK);
    end

    sseg_hex_decode u_decode (
        .pattern (sseg_r[6:0]),
        .ok      (dec_ok),
        .nibble  (dec_nib)
    );

    // Pin registers and stability counter; any pin change restarts qualification.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r   <= {NUM_DIGITS{1'b1}};
            sseg_r <= SSEG_BLANK;
            cnt    <= 8'd0;
        end else begin
            an_r   <= an_in;
            sseg_r <= sseg_in;
            if (!pins_eq) begin
                cnt <= 8'd0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Per-digit banks, frame tracking and illegal-strobe counting on a qualifying edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_pat  <= {NUM_DIGITS{SSEG_BLANK}};
            hex_val    <= '0;
            hex_ok     <= '0;
            dp_val     <= '0;
            frame_tick <= 1'b0;
            err_cnt    <= 8'd0;
            seen       <= '0;
        end else begin
            frame_tick <= 1'b0;
            if (qualify && strobe == STROBE_LEGAL) begin
                digit_pat[{sel, 3'b000} +: 8] <= sseg_r;
                hex_val[{sel, 2'b00} +: 4]    <= dec_nib;
                hex_ok[sel]                   <= dec_ok;
                dp_val[sel]                   <= ~sseg_r[7];
                if (frame_done) begin
                    frame_tick <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen_next;
                end
            end else if (qualify && strobe == STROBE_ILLEGAL) begin
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule
